instr_decode_stage: RTL
=======================

Name: instr_decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Sits between fetch and execute. Decodes every RV32I base format (R/I/S/B/U/J) to ALU function, register indices, and a sign-correct immediate.
- Adds illegal-instruction flagging, flush, and a saturating illegal-instruction counter.
- Two-entry skid buffer gives full throughput while keeping in_ready registered.

Parameters:
- XLEN, 32, datapath width for pc and immediate; legal values 32 or 64.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered entries this cycle.
- in_valid  input  1  fetch presents instr/in_pc.
- in_ready  output  1  stage can accept; registered output.
- instr  input  32  instruction word.
- in_pc  input  XLEN  pc of instr.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  execute accepts the entry.
- out_pc  output  XLEN  pc of the entry.
- alu_funct  output  ALU_FUNCT_WIDTH  ALU operation code.
- rs1, rs2, rd  output  5 each  register indices.
- immed  output  XLEN  extended immediate.
- imm_fmt  output  3  IMM_FMT_{NONE,I,S,B,U,J,SHAMT}.
- illegal  output  1  entry is not a valid RV32I instruction.
- illegal_count  output  CNT_W  saturating count of illegal entries accepted.

Behaviour:
- Reset is synchronous and active-high on rst, sampled on clk. It clears both buffer entries and illegal_count.
  - Reset state: out_valid=0, in_ready=1, all data outputs 0.
  - Reset asserted mid-transfer drops any entry in flight.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Latency: 1 cycle. An entry accepted at edge N is presented with out_valid=1 after edge N.
- Buffer states: EMPTY, ONE (main register valid), FULL (main + skid valid).
  - EMPTY + accept -> ONE.
  - ONE + accept + no drain -> FULL.
  - ONE + drain + no accept -> EMPTY.
  - ONE + accept + drain -> ONE (pass-through).
  - FULL + drain -> ONE, with the skid entry promoted to main.
  - in_ready = (state != FULL), registered.
  - Never accept in FULL. Order is strictly FIFO.
- flush:
  - Next state is EMPTY and in_ready=1; any same-cycle input transfer is discarded.
  - flush overrides out_ready: the entry is dropped, not counted as transferred.
  - Counter increments from the flushed cycle are suppressed.
- Decode is combinational on instr and is registered at the input transfer.
- ALU function:
  - For OPCODE_ALU_REG and OPCODE_ALU_IMM, select by funct3.
  - funct3 ADD: funct7 BASE -> ADD; ALT1 -> SUB, R-type only. ALT1 on ALU_IMM is treated as ADDI, because funct7 bits are immediate there.
  - funct3 SRL: funct7 BASE -> SRL; ALT1 -> SRA. Applies to both R-type and I-type.
  - funct7 values other than BASE/ALT1 where they are meaningful -> illegal=1, alu_funct=ADD.
  - All other opcodes -> ADD.
- Immediates, sign-extended to XLEN from instr[31]:
  - I-type: LOAD, JALR, ALU_IMM.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits zero.
  - J-type: JAL, bit0=0.
  - SLLI/SRLI/SRAI: SHAMT = zero-extended instr[24:20].
  - All other opcodes: immed=0, fmt NONE.
- illegal=1 when any of these hold:
  - opcode is not in the RV32I set.
  - instr[1:0] != 2'b11.
  - Reserved funct3 for LOAD/STORE/BRANCH.
  - SLLI has nonzero funct7.
- illegal_count increments by 1 per accepted illegal entry and saturates at all-ones.
- rs1/rs2/rd always equal the raw instr fields.

Decomposition:
- Extend the shared defines headers with:
  - all RV32I opcodes;
  - IMM_FMT_* codes and IMM_FMT_WIDTH;
  - funct3 load/store/branch legal sets.
- Reuse the existing ALU_FUNCT_* codes.
- Sub-module instr_decode_comb: a pure combinational decoder (instr -> alu_funct, reg indices, immed, imm_fmt, illegal), parametrised by XLEN.
- The top module holds the skid buffer, flush logic and counter.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, immed=0xFFFFFFFF, alu=ADD, fmt=I, illegal=0.
- Back-to-back stream:
  - sub x3,x1,x2 (0x402081B3) -> alu=SUB.
  - srai x5,x6,3 (0x40335293) -> alu=SRA, immed=3, fmt=SHAMT.
  - sw x2,8(x1) (0x0020A423) -> immed=8, fmt=S.
  - Required: one result per cycle, in order.
- out_ready=0 while sending 3 instrs:
  - in_ready falls after 2 accepted; outputs are stable.
  - Release out_ready -> order is preserved and the third instr is accepted.
- beq x0,x0,-4 (0xFE000EE3) -> immed=0xFFFFFFFC, fmt=B. jal x1,+2048 (0x001000EF) -> immed=0x800, fmt=J.
- Illegal words 0x00000000 and 0x0000707F are accepted -> illegal=1, alu=ADD, illegal_count=2. Preset the counter to max -> it stays at max.
- FULL state, assert flush for one cycle -> out_valid=0, in_ready=1 next cycle. Assert rst mid-stream -> all outputs are 0 and the count is 0 after the edge.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared RV32I encodings, ALU function codes and immediate-format codes
// for the instruction-decode stage and its combinational decoder.
package instr_decode_stage_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_ADD  = 4'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SUB  = 4'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLL  = 4'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLT  = 4'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLTU = 4'd4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_XOR  = 4'd5;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRL  = 4'd6;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRA  = 4'd7;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_OR   = 4'd8;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_AND  = 4'd9;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_ALU_IMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_ALU_REG  = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam int IMM_FMT_WIDTH = 3;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_NONE  = 3'd0;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_I     = 3'd1;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_S     = 3'd2;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_B     = 3'd3;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_U     = 3'd4;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_J     = 3'd5;
  localparam logic [IMM_FMT_WIDTH-1:0] IMM_FMT_SHAMT = 3'd6;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT1 = 7'b0100000;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_e;

  // LB/LH/LW/LBU/LHU
  function automatic logic load_funct3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // SB/SH/SW
  function automatic logic store_funct3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  // BEQ/BNE/BLT/BGE/BLTU/BGEU; 010 and 011 are reserved
  function automatic logic branch_funct3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic logic [ALU_FUNCT_WIDTH-1:0] base_alu_funct(input logic [2:0] f3);
    case (f3)
      FUNCT3_ADD:  return ALU_FUNCT_ADD;
      FUNCT3_SLL:  return ALU_FUNCT_SLL;
      FUNCT3_SLT:  return ALU_FUNCT_SLT;
      FUNCT3_SLTU: return ALU_FUNCT_SLTU;
      FUNCT3_XOR:  return ALU_FUNCT_XOR;
      FUNCT3_SRL:  return ALU_FUNCT_SRL;
      FUNCT3_OR:   return ALU_FUNCT_OR;
      default:     return ALU_FUNCT_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_decode.sv
// Pure combinational RV32I decoder: instruction word to ALU function,
// register indices, sign-correct immediate, immediate format and illegal flag.
module instr_decode_comb
  import instr_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]                instr,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            immed,
  output logic [IMM_FMT_WIDTH-1:0]   imm_fmt,
  output logic                       illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic signed [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // imm32 is signed, so the width cast sign-extends when XLEN is 64
  assign immed = XLEN'(imm32);

  always_comb begin
    alu_funct = ALU_FUNCT_ADD;
    imm32     = '0;
    imm_fmt   = IMM_FMT_NONE;
    illegal   = 1'b0;

    case (opcode)
      OPCODE_LOAD: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        imm_fmt = IMM_FMT_I;
        illegal = !load_funct3_legal(funct3);
      end
      OPCODE_STORE: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_fmt = IMM_FMT_S;
        illegal = !store_funct3_legal(funct3);
      end
      OPCODE_BRANCH: begin
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_fmt = IMM_FMT_B;
        illegal = !branch_funct3_legal(funct3);
      end
      OPCODE_JALR: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        imm_fmt = IMM_FMT_I;
      end
      OPCODE_JAL: begin
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_fmt = IMM_FMT_J;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        imm32   = {instr[31:12], 12'b0};
        imm_fmt = IMM_FMT_U;
      end
      OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
        alu_funct = ALU_FUNCT_ADD;
      end
      OPCODE_ALU_IMM: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        imm_fmt = IMM_FMT_I;
        // Shifts carry a 5-bit shamt; funct7 selects logical/arithmetic
        if (funct3 == FUNCT3_SLL) begin
          imm32   = {27'b0, instr[24:20]};
          imm_fmt = IMM_FMT_SHAMT;
          if (funct7 == FUNCT7_BASE) alu_funct = ALU_FUNCT_SLL;
          else                       illegal   = 1'b1;
        end else if (funct3 == FUNCT3_SRL) begin
          imm32   = {27'b0, instr[24:20]};
          imm_fmt = IMM_FMT_SHAMT;
          if (funct7 == FUNCT7_BASE)      alu_funct = ALU_FUNCT_SRL;
          else if (funct7 == FUNCT7_ALT1) alu_funct = ALU_FUNCT_SRA;
          else                            illegal   = 1'b1;
        end else begin
          alu_funct = base_alu_funct(funct3);
        end
      end
      OPCODE_ALU_REG: begin
        if (funct7 == FUNCT7_BASE)                              alu_funct = base_alu_funct(funct3);
        else if (funct7 == FUNCT7_ALT1 && funct3 == FUNCT3_ADD) alu_funct = ALU_FUNCT_SUB;
        else if (funct7 == FUNCT7_ALT1 && funct3 == FUNCT3_SRL) alu_funct = ALU_FUNCT_SRA;
        else                                                    illegal   = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (instr[1:0] != 2'b11) illegal = 1'b1;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decodes at the input transfer into a two-entry
// skid buffer, with flush and a saturating illegal-instruction counter.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [XLEN-1:0]            immed,
  output logic [IMM_FMT_WIDTH-1:0]   imm_fmt,
  output logic                       illegal,
  output logic [CNT_W-1:0]           illegal_count
);

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [XLEN-1:0]            immed;
    logic [IMM_FMT_WIDTH-1:0]   imm_fmt;
    logic                       illegal;
  } entry_t;

  logic [ALU_FUNCT_WIDTH-1:0] dec_alu_funct;
  logic [4:0]                 dec_rs1;
  logic [4:0]                 dec_rs2;
  logic [4:0]                 dec_rd;
  logic [XLEN-1:0]            dec_immed;
  logic [IMM_FMT_WIDTH-1:0]   dec_imm_fmt;
  logic                       dec_illegal;

  entry_t     dec_entry;
  entry_t     main_q;
  entry_t     skid_q;
  buf_state_e state;
  logic       accept;
  logic       drain;

  instr_decode_comb #(
    .XLEN(XLEN)
  ) u_decode (
    .instr    (instr),
    .alu_funct(dec_alu_funct),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .immed    (dec_immed),
    .imm_fmt  (dec_imm_fmt),
    .illegal  (dec_illegal)
  );

  assign dec_entry = '{pc:        in_pc,
                       alu_funct: dec_alu_funct,
                       rs1:       dec_rs1,
                       rs2:       dec_rs2,
                       rd:        dec_rd,
                       immed:     dec_immed,
                       imm_fmt:   dec_imm_fmt,
                       illegal:   dec_illegal};

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // main_q always holds the head of the FIFO; skid_q only fills when the
  // consumer stalls while a new entry arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BUF_EMPTY;
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
      main_q        <= '0;
      skid_q        <= '0;
      illegal_count <= '0;
    end else if (flush) begin
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (accept && dec_illegal && illegal_count != '1)
        illegal_count <= illegal_count + 1'b1;

      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            main_q    <= dec_entry;
            state     <= BUF_ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (accept && !drain) begin
            skid_q   <= dec_entry;
            state    <= BUF_FULL;
            in_ready <= 1'b0;
          end else if (accept && drain) begin
            main_q <= dec_entry;
          end else if (drain) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            main_q   <= skid_q;
            state    <= BUF_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_pc    = main_q.pc;
  assign alu_funct = main_q.alu_funct;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign immed     = main_q.immed;
  assign imm_fmt   = main_q.imm_fmt;
  assign illegal   = main_q.illegal;

endmodule
